// File: rtl/trng_pkg.sv
// Shared TRNG definitions: entropy word width and collector FSM encoding.
package trng_pkg;
  localparam int ENTROPY_WORD_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PRESENT = 2'd2,
    ST_ERROR   = 2'd3
  } col_state_e;
endpackage

// File: rtl/entropy_collector_if.sv
// Source-side and mixer-side syn/ack handshakes of the entropy collector.
//   src_syn/src_data -> collector, src_ack <- collector (word side)
//   blk_syn/blk_data <- collector, blk_ack -> collector (block side)
// slave = collector view, master = environment view.
interface entropy_collector_if #(parameter int NUM_WORDS = 16);
  import trng_pkg::*;

  logic                                    src_syn;
  logic [ENTROPY_WORD_WIDTH-1:0]           src_data;
  logic                                    src_ack;
  logic                                    blk_syn;
  logic [NUM_WORDS*ENTROPY_WORD_WIDTH-1:0] blk_data;
  logic                                    blk_ack;

  modport slave  (input  src_syn, src_data, blk_ack,
                  output src_ack, blk_syn, blk_data);
  modport master (output src_syn, src_data, blk_ack,
                  input  src_ack, blk_syn, blk_data);
endinterface

// File: rtl/entropy_rep_checker.sv
// Repetition health check on captured entropy words.
//   clk, reset : clock, synchronous active-high reset
//   clear      : drop history (collector disabled)
//   valid/word : a captured word
//   error      : sticky, set when rep_cnt reaches REP_LIMIT
//   rep_cnt    : current run length of identical words (saturating)
//   trip       : this valid word completes a failing run (same-cycle)
module entropy_rep_checker
  import trng_pkg::*;
#(
  parameter int REP_LIMIT = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          valid,
  input  logic [ENTROPY_WORD_WIDTH-1:0] word,
  output logic                          error,
  output logic [7:0]                    rep_cnt,
  output logic                          trip
);
  localparam logic [7:0] LIM = 8'(REP_LIMIT);

  logic [ENTROPY_WORD_WIDTH-1:0] prev;
  logic [7:0]                    cnt_n;

  // rep_cnt == 0 means no history yet, so a zero word after clear is not a repeat.
  always_comb begin
    cnt_n = 8'd1;
    if (rep_cnt != 8'd0 && word == prev)
      cnt_n = (rep_cnt == LIM) ? rep_cnt : rep_cnt + 8'd1;
  end

  assign trip = valid && (cnt_n == LIM);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      prev    <= '0;
      rep_cnt <= '0;
      error   <= 1'b0;
    end else if (valid) begin
      prev    <= word;
      rep_cnt <= cnt_n;
      if (trip) error <= 1'b1;
    end
  end
endmodule

// File: rtl/entropy_collector.sv
// Packs NUM_WORDS entropy words into a block and hands it to the mixer.
//   clk, reset      : clock, synchronous active-high reset
//   enable          : low returns to IDLE and drops all collection state
//   bus (slave)     : src_syn/src_data/src_ack word handshake,
//                     blk_syn/blk_data/blk_ack block handshake
//   rep_error       : sticky repetition-check failure
//   words_collected : wrapping count of captured words (reset only)
module entropy_collector
  import trng_pkg::*;
#(
  parameter int NUM_WORDS = 16,
  parameter int REP_LIMIT = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  entropy_collector_if.slave  bus,
  output logic                rep_error,
  output logic [31:0]         words_collected
);
  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam int WW    = ENTROPY_WORD_WIDTH;

  col_state_e                   state, state_n;
  logic [IDX_W-1:0]             idx;
  logic [NUM_WORDS-1:0][WW-1:0] blk_q;
  logic                         src_ack_q;
  logic                         capture, last, trip;
  logic [7:0]                   rep_cnt;

  entropy_rep_checker #(.REP_LIMIT(REP_LIMIT)) u_rep (
    .clk     (clk),
    .reset   (reset),
    .clear   (!enable),
    .valid   (capture),
    .word    (bus.src_data),
    .error   (rep_error),
    .rep_cnt (rep_cnt),
    .trip    (trip)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Next state; a tripping capture goes to ERROR even if it fills the block.
  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:    state_n = ST_COLLECT;
      ST_COLLECT: if (capture && trip)      state_n = ST_ERROR;
                  else if (capture && last) state_n = ST_PRESENT;
      ST_PRESENT: if (bus.blk_ack)          state_n = ST_COLLECT;
      ST_ERROR:   state_n = ST_ERROR;
    endcase
    if (!enable) state_n = ST_IDLE;
  end

  // Capture strobes; the src_ack term spaces captures two cycles apart.
  always_comb begin
    capture = enable && (state == ST_COLLECT) && bus.src_syn && !src_ack_q;
    last    = (idx == IDX_W'(NUM_WORDS - 1));
  end

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      idx       <= '0;
      blk_q     <= '0;
      src_ack_q <= 1'b0;
    end else begin
      src_ack_q <= capture;
      if (capture) begin
        blk_q[idx] <= bus.src_data;
        idx        <= last ? '0 : idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)        words_collected <= '0;
    else if (capture) words_collected <= words_collected + 32'd1;
  end

  // A run at the limit must already have moved the FSM out of COLLECT.
  always_ff @(posedge clk) begin
    if (!reset && state == ST_COLLECT)
      assert (rep_cnt < 8'(REP_LIMIT));
  end

  assign bus.src_ack  = src_ack_q;
  assign bus.blk_syn  = (state == ST_PRESENT);
  assign bus.blk_data = blk_q;
endmodule

// File: tb/tb_entropy_collector.sv
module tb_entropy_collector;
  localparam int NW = 4;
  localparam int RL = 3;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic        rep_error;
  logic [31:0] words_collected;
  int          nchk = 0;
  int          nerr = 0;

  entropy_collector_if #(.NUM_WORDS(NW)) bus ();

  entropy_collector #(.NUM_WORDS(NW), .REP_LIMIT(RL)) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .bus             (bus.slave),
    .rep_error       (rep_error),
    .words_collected (words_collected)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0;
    bus.src_syn = 1'b0; bus.src_data = '0; bus.blk_ack = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
  endtask

  // Steps until blk_syn, advancing src_data after each src_ack.
  task automatic run_block(input string tag);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (bus.src_ack) bus.src_data = bus.src_data + 32'd1;
      seen = bus.blk_syn;
    end
    chk({tag, "_blk_syn_timeout"}, 128'(seen), 128'd1);
  endtask

  initial begin
    logic [127:0] held;
    bit bad_syn, bad_ack, bad_dat;

    // Reset values
    do_reset();
    chk("rst_src_ack", 128'(bus.src_ack), 128'd0);
    chk("rst_blk_syn", 128'(bus.blk_syn), 128'd0);
    chk("rst_rep_error", 128'(rep_error), 128'd0);
    chk("rst_words", 128'(words_collected), 128'd0);
    chk("rst_blk_data", bus.blk_data, 128'd0);

    // Incrementing source: acks at cycles 1,3,5,7, block on the 4th capture
    enable = 1'b1; bus.src_syn = 1'b1; bus.src_data = 32'd1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("inc_ack_c%0d", k), 128'(bus.src_ack), 128'(k % 2));
      if (k == 5) chk("inc_blk_syn_early", 128'(bus.blk_syn), 128'd0);
      if (bus.src_ack) bus.src_data = bus.src_data + 32'd1;
    end
    chk("inc_blk_syn", 128'(bus.blk_syn), 128'd1);
    chk("inc_blk_data", bus.blk_data, 128'h00000004_00000003_00000002_00000001);
    chk("inc_words", 128'(words_collected), 128'd4);

    // Backpressure: 10 cycles without blk_ack
    held = bus.blk_data;
    bad_syn = 0; bad_ack = 0; bad_dat = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (!bus.blk_syn) bad_syn = 1;
      if (bus.src_ack) bad_ack = 1;
      if (bus.blk_data !== held) bad_dat = 1;
    end
    chk("bp_blk_syn_held", 128'(bad_syn), 128'd0);
    chk("bp_no_ack", 128'(bad_ack), 128'd0);
    chk("bp_data_stable", 128'(bad_dat), 128'd0);
    bus.blk_ack = 1'b1;
    step();
    chk("bp_blk_syn_drop", 128'(bus.blk_syn), 128'd0);
    bus.blk_ack = 1'b0;
    step();
    chk("bp_resume_ack", 128'(bus.src_ack), 128'd1);
    chk("bp_resume_word", 128'(bus.blk_data[31:0]), 128'd5);
    chk("bp_resume_words", 128'(words_collected), 128'd5);

    // Stuck source
    do_reset();
    enable = 1'b1; bus.src_syn = 1'b1; bus.src_data = 32'h01020304;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("stuck_err_c%0d", k), 128'(rep_error), 128'(k == 5));
    end
    bad_syn = 0; bad_ack = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (bus.blk_syn) bad_syn = 1;
      if (bus.src_ack) bad_ack = 1;
    end
    chk("stuck_no_blk", 128'(bad_syn), 128'd0);
    chk("stuck_no_ack", 128'(bad_ack), 128'd0);
    chk("stuck_err_held", 128'(rep_error), 128'd1);
    chk("stuck_words", 128'(words_collected), 128'd3);
    enable = 1'b0;
    step();
    chk("stuck_err_clear", 128'(rep_error), 128'd0);

    // Enable drop after 2 captures
    do_reset();
    enable = 1'b1; bus.src_syn = 1'b1; bus.src_data = 32'h11;
    for (int k = 0; k < 4; k++) begin
      step();
      if (bus.src_ack) bus.src_data = bus.src_data + 32'd1;
    end
    enable = 1'b0;
    step();
    chk("drop_words", 128'(words_collected), 128'd2);
    chk("drop_ack", 128'(bus.src_ack), 128'd0);
    chk("drop_blk_data", bus.blk_data, 128'd0);
    enable = 1'b1; bus.src_data = 32'hA1;
    run_block("drop");
    chk("drop_new_block", bus.blk_data, 128'h000000A4_000000A3_000000A2_000000A1);
    chk("drop_new_words", 128'(words_collected), 128'd6);

    // Reset during PRESENT
    do_reset();
    enable = 1'b1; bus.src_syn = 1'b1; bus.src_data = 32'd1;
    run_block("rstp");
    reset = 1'b1;
    step();
    chk("rstp_blk_syn", 128'(bus.blk_syn), 128'd0);
    chk("rstp_blk_data", bus.blk_data, 128'd0);
    chk("rstp_words", 128'(words_collected), 128'd0);
    reset = 1'b0; enable = 1'b0;
    bad_ack = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (bus.src_ack) bad_ack = 1;
    end
    chk("rstp_no_ack_disabled", 128'(bad_ack), 128'd0);
    enable = 1'b1;
    step();
    chk("rstp_ack_c0", 128'(bus.src_ack), 128'd0);
    step();
    chk("rstp_ack_c1", 128'(bus.src_ack), 128'd1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/entropy_collector.md
# entropy_collector

Consumer end of the entropy-source syn/ack word interface. Accepts 32-bit words from one entropy source, packs NUM_WORDS consecutive words into a block, and presents the block to the downstream mixer with its own syn/ack handshake. Runs a repetition health check on the incoming words and stops on a stuck source. Also keeps a running count of captured words for the status registers.

## Interface
- NUM_WORDS, 16: words per block (2..64).
- REP_LIMIT, 8: number of consecutive identical captured words that flags an error (2..255).
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  collector enable; low clears all collection state.
- src_syn  in  1  source has a valid word on src_data.
- src_data  in  32  source entropy word.
- src_ack  out  1  one-cycle pulse: word captured.
- blk_syn  out  1  block valid on blk_data.
- blk_data  out  NUM_WORDS*32  assembled block; word i occupies bits [32*i+31 : 32*i].
- blk_ack  in  1  mixer has taken the block.
- rep_error  out  1  repetition check failed (sticky).
- words_collected  out  32  total captured words, wrapping.

## Operation
- FSM states: IDLE, COLLECT, PRESENT, ERROR.
  - IDLE -> COLLECT when enable = 1.
  - Any state -> IDLE when enable = 0. This discards the partial block and clears the word index, rep counter, previous word, rep_error, blk_syn and src_ack.
- Capture condition: state = COLLECT, src_syn = 1 and src_ack = 0.
  - On capture, src_data is written into word slot idx and idx increments.
  - src_ack is registered 1 for exactly the following cycle.
  - A source that holds syn continuously is therefore captured at most every 2nd cycle.
- Block full: the capture into slot NUM_WORDS-1 sets idx to 0 and moves the FSM to PRESENT.
- PRESENT:
  - blk_syn = 1; blk_data is held stable.
  - No captures occur, so src_ack stays 0 (backpressure).
  - When blk_ack is sampled 1: blk_syn -> 0 and the FSM returns to COLLECT. blk_ack is ignored outside PRESENT.
- Repetition check (on every capture):
  - If the word equals the previous captured word, rep_cnt increments; otherwise rep_cnt = 1.
  - The first capture after enable/reset sets rep_cnt = 1.
  - rep_cnt saturates at REP_LIMIT.
  - The previous word and rep_cnt persist across block boundaries.
  - When rep_cnt reaches REP_LIMIT: rep_error -> 1 and the FSM -> ERROR. ERROR wins over block-full, so that block is never presented.
  - In ERROR there are no captures, blk_syn = 0, and rep_error is held until enable = 0 or reset.
- words_collected:
  - increments on every capture, wrapping 0xFFFFFFFF -> 0;
  - is cleared only by reset, not by enable = 0.

## Timing
- Reset values:
  - state = IDLE; src_ack = 0, blk_syn = 0, rep_error = 0, words_collected = 0;
  - blk_data = all zeros; idx = 0, rep_cnt = 0.
- src_ack latency: high in the cycle after the capturing edge.
- blk_syn latency: high from the edge that captures the last word.
- Throughput:
  - With blk_ack tied high, blk_syn is high for 1 cycle.
  - The next block's first capture is possible at the edge after blk_ack is sampled.
- Simultaneous events:
  - enable = 0 overrides everything: blk_ack, capture and the error transition.
  - Reset overrides enable.
  - Reset mid-block discards all state.
- Outputs are driven only from registers; no combinational paths from inputs to outputs.

## Structure
- Shared package trng_pkg holds:
  - ENTROPY_WORD_WIDTH = 32;
  - the collector state encoding (IDLE/COLLECT/PRESENT/ERROR as a 2-bit enum).
- Sub-module entropy_rep_checker, with inputs clk, reset, clear, valid, word and outputs error, rep_cnt. It owns the previous-word register and the saturating counter.
- The collector top holds the FSM, the slot index, the block register and words_collected.

## Test plan
All scenarios use NUM_WORDS = 4 and REP_LIMIT = 3.
- Incrementing source: src_syn held 1, data 1,2,3,4 advancing on each src_ack.
  - -> src_ack pulses at cycles 1, 3, 5, 7 after enable.
  - -> blk_syn rises with the 4th capture.
  - -> blk_data = 0x00000004_00000003_00000002_00000001; words_collected = 4.
- Backpressure: the same 4 words are captured, then blk_ack is held 0 for 10 cycles.
  - -> blk_syn stays 1, blk_data is unchanged and src_ack stays 0.
  - -> blk_ack pulse -> blk_syn 0 on the next edge, and capture resumes 1 cycle later.
- Stuck source: constant 0x01020304 with syn held.
  - -> rep_error rises with the 3rd capture; blk_syn never rises; words_collected = 3.
  - -> enable 0 for 1 cycle clears rep_error.
- Enable drop after 2 captures.
  - -> after re-enable, the next block starts at slot 0; words_collected = 2 before the new captures.
  - -> the first 4 new words appear alone in blk_data.
- Reset during PRESENT.
  - -> blk_syn = 0, blk_data = 0, words_collected = 0 on the following cycle.
  - -> no src_ack until enable is seen high again.
